// File: rtl/twiddle_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_mul_sched
// Description : Round-robin scheduler sharing one fixed-latency W8 twiddle
//               multiplier between two butterfly requesters. Operand pairs are
//               accepted over a req/gnt handshake, registered onto the
//               multiplier inputs, tracked through a valid/id tag pipe matched
//               to the multiplier latency, and returned id-tagged through a
//               registered result port.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               req0/ra0/rb0/gnt0         requester 0 handshake and operands
//               req1/ra1/rb1/gnt1         requester 1 handshake and operands
//               mul_ra, mul_rb            registered operands to the multiplier
//               mul_real, mul_image       multiplier results (LAT cycles later)
//               res_valid/res_id          registered result strobe and owner
//               res_real/res_image        registered copies of the results
//               idle                      registered: nothing in flight
// Parameters  : N   - data width is 2**N bits
//               LAT - multiplier latency in cycles, legal range 1..8
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_mul_sched #(
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [(2**N)-1:0]   ra0,
    input  logic [(2**N)-1:0]   rb0,
    output logic                gnt0,
    input  logic                req1,
    input  logic [(2**N)-1:0]   ra1,
    input  logic [(2**N)-1:0]   rb1,
    output logic                gnt1,
    output logic [(2**N)-1:0]   mul_ra,
    output logic [(2**N)-1:0]   mul_rb,
    input  logic [(2**N)-1:0]   mul_real,
    input  logic [(2**N)-1:0]   mul_image,
    output logic                res_valid,
    output logic                res_id,
    output logic [(2**N)-1:0]   res_real,
    output logic [(2**N)-1:0]   res_image,
    output logic                idle
);

    localparam int c_W = 2**N;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             r_ptr_q;
    logic             w_ptr_d;
    logic [c_W-1:0]   r_mul_ra_q, w_mul_ra_d;
    logic [c_W-1:0]   r_mul_rb_q, w_mul_rb_d;
    logic [LAT:0]     r_vld_q, w_vld_d;     // tag pipe valids, stage 0..LAT
    logic [LAT:0]     r_id_q,  w_id_d;      // tag pipe requester ids
    logic             r_res_valid_q, w_res_valid_d;
    logic             r_res_id_q,    w_res_id_d;
    logic [c_W-1:0]   r_res_real_q;
    logic [c_W-1:0]   r_res_image_q;
    logic             r_idle_q, w_idle_d;

    // ------------------------------------------------------------------
    // Arbiter: a lone requester always wins; under contention the
    // requester named by the pointer wins. Grants are suppressed during
    // reset so nothing is handshaken away while state is being cleared.
    // ------------------------------------------------------------------
    logic w_sel;
    logic w_grant;

    always_comb begin
        w_sel = 1'b0;
        if (req0 && req1) begin
            w_sel = r_ptr_q;
        end else if (req1) begin
            w_sel = 1'b1;
        end
    end

    assign w_grant = (req0 | req1) & ~rst;
    assign gnt0    = w_grant & req0 & ~w_sel;
    assign gnt1    = w_grant & req1 &  w_sel;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // pointer flips away from whoever was just served
        w_ptr_d    = w_grant ? ~w_sel : r_ptr_q;

        // multiplier operands hold when nothing is issued
        w_mul_ra_d = r_mul_ra_q;
        w_mul_rb_d = r_mul_rb_q;
        if (w_grant) begin
            w_mul_ra_d = w_sel ? ra1 : ra0;
            w_mul_rb_d = w_sel ? rb1 : rb0;
        end

        // tag pipe shifts every cycle; stage LAT lines up with mul_real
        w_vld_d = {r_vld_q[LAT-1:0], w_grant};
        w_id_d  = {r_id_q[LAT-1:0],  w_grant & w_sel};

        w_res_valid_d = r_vld_q[LAT];
        w_res_id_d    = r_id_q[LAT];

        // idle is computed from next-state values so the registered flag
        // describes the same cycle as the other registered outputs
        w_idle_d = ~(|w_vld_d) & ~w_res_valid_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q       <= 1'b0;
            r_mul_ra_q    <= '0;
            r_mul_rb_q    <= '0;
            r_vld_q       <= '0;
            r_id_q        <= '0;
            r_res_valid_q <= 1'b0;
            r_res_id_q    <= 1'b0;
            r_res_real_q  <= '0;
            r_res_image_q <= '0;
            r_idle_q      <= 1'b1;
        end else begin
            r_ptr_q       <= w_ptr_d;
            r_mul_ra_q    <= w_mul_ra_d;
            r_mul_rb_q    <= w_mul_rb_d;
            r_vld_q       <= w_vld_d;
            r_id_q        <= w_id_d;
            r_res_valid_q <= w_res_valid_d;
            r_res_id_q    <= w_res_id_d;
            r_res_real_q  <= mul_real;
            r_res_image_q <= mul_image;
            r_idle_q      <= w_idle_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mul_ra    = r_mul_ra_q;
    assign mul_rb    = r_mul_rb_q;
    assign res_valid = r_res_valid_q;
    assign res_id    = r_res_id_q;
    assign res_real  = r_res_real_q;
    assign res_image = r_res_image_q;
    assign idle      = r_idle_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_mul_sched
// Description : Self-checking bench for twiddle_mul_sched. A stub multiplier
//               with three cycles of latency returns ra-rb / ra+rb. Grants are
//               checked against a vector table; results are checked against a
//               scoreboard of expected {id, data, arrival cycle} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_mul_sched;

    localparam int c_N   = 4;
    localparam int c_LAT = 3;
    localparam int c_W   = 2**c_N;

    logic           clk;
    logic           rst;
    logic           req0, req1;
    logic [c_W-1:0] ra0, rb0, ra1, rb1;
    logic           gnt0, gnt1;
    logic [c_W-1:0] mul_ra, mul_rb, mul_real, mul_image;
    logic           res_valid, res_id, idle;
    logic [c_W-1:0] res_real, res_image;

    twiddle_mul_sched #(.N(c_N), .LAT(c_LAT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .ra0       (ra0),
        .rb0       (rb0),
        .gnt0      (gnt0),
        .req1      (req1),
        .ra1       (ra1),
        .rb1       (rb1),
        .gnt1      (gnt1),
        .mul_ra    (mul_ra),
        .mul_rb    (mul_rb),
        .mul_real  (mul_real),
        .mul_image (mul_image),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_real  (res_real),
        .res_image (res_image),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stub multiplier: three register stages after mul_ra/mul_rb
    logic [c_W-1:0] r_re1, r_re2, r_re3, r_im1, r_im2, r_im3;
    always @(posedge clk) begin
        if (rst) begin
            r_re1 <= '0; r_re2 <= '0; r_re3 <= '0;
            r_im1 <= '0; r_im2 <= '0; r_im3 <= '0;
        end else begin
            r_re1 <= mul_ra - mul_rb;
            r_im1 <= mul_ra + mul_rb;
            r_re2 <= r_re1; r_re3 <= r_re2;
            r_im2 <= r_im1; r_im3 <= r_im2;
        end
    end
    assign mul_real  = r_re3;
    assign mul_image = r_im3;

    typedef struct {
        bit             r0;
        logic [c_W-1:0] a0, b0;
        bit             r1;
        logic [c_W-1:0] a1, b1;
        bit             g0, g1;
    } vec_t;

    typedef struct {
        bit             id;
        logic [c_W-1:0] re, im;
        int             due;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // result side of the scoreboard, sampled on the falling edge
    task automatic check_result();
        exp_t e;
        if (res_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got id=%0d re=%0h im=%0h expected no result (cycle %0d)",
                         res_id, res_real, res_image, cyc);
            end else begin
                e = sb.pop_front();
                if (e.due != cyc || res_id !== e.id || res_real !== e.re || res_image !== e.im) begin
                    n_fail++;
                    $display("FAIL result: got id=%0d re=%0h im=%0h at cycle %0d expected id=%0d re=%0h im=%0h at cycle %0d",
                             res_id, res_real, res_image, cyc, e.id, e.re, e.im, e.due);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            e = sb.pop_front();
            $display("FAIL missing_result: got res_valid=0 expected id=%0d re=%0h im=%0h at cycle %0d",
                     e.id, e.re, e.im, e.due);
        end
    endtask

    // one clock cycle: drive, check grant, push expectation, check result
    task automatic tick(input bit r0, input logic [c_W-1:0] a0, input logic [c_W-1:0] b0,
                        input bit r1, input logic [c_W-1:0] a1, input logic [c_W-1:0] b1,
                        input bit eg0, input bit eg1, input string nm);
        exp_t e;
        req0 = r0; ra0 = a0; rb0 = b0;
        req1 = r1; ra1 = a1; rb1 = b1;
        #2;
        chk({nm, "_gnt"}, {30'd0, gnt0, gnt1}, {30'd0, eg0, eg1});
        if (eg0 || eg1) begin
            e.id  = eg1;
            e.re  = eg1 ? (a1 - b1) : (a0 - b0);
            e.im  = eg1 ? (a1 + b1) : (a0 + b0);
            e.due = cyc + c_LAT + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        check_result();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_idle();
        tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, "idle");
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mul_ra"},    {16'd0, mul_ra},    32'd0);
        chk({tag, "_mul_rb"},    {16'd0, mul_rb},    32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_id"},    {31'd0, res_id},    32'd0);
        chk({tag, "_res_real"},  {16'd0, res_real},  32'd0);
        chk({tag, "_res_image"}, {16'd0, res_image}, 32'd0);
        chk({tag, "_idle"},      {31'd0, idle},      32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && (sb.size() != 0 || idle !== 1'b1); i++) tick_idle();
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
        chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        // lone req1 with fresh operands each cycle
        vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0200, 16'h0002, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0300, 16'h0003, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0400, 16'h0004, 1'b0, 1'b1};
        // contention: loser holds its operands, winner presents fresh ones
        vecs[4]  = '{1'b1, 16'h1000, 16'h0010, 1'b1, 16'h2000, 16'h0020, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 16'h1100, 16'h0011, 1'b1, 16'h2000, 16'h0020, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h1100, 16'h0011, 1'b1, 16'h2100, 16'h0021, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 16'h1200, 16'h0012, 1'b1, 16'h2100, 16'h0021, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'h1200, 16'h0012, 1'b1, 16'h2200, 16'h0022, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h1300, 16'h0013, 1'b1, 16'h2200, 16'h0022, 1'b0, 1'b1};
        // hold rule with a gap in issue
        vecs[10] = '{1'b1, 16'h5000, 16'h0500, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h6000, 16'h0600, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h5100, 16'h0510, 1'b1, 16'h6100, 16'h0610, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h6100, 16'h0610, 1'b0, 1'b1};
        // full-width wrap passes through untouched
        vecs[15] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        req0 = 1'b0; ra0 = '0; rb0 = '0;
        req1 = 1'b0; ra1 = '0; rb1 = '0;
        @(posedge clk);
        #1;
        tick_idle();
        tick(1'b1, 16'h1234, 16'h0001, 1'b1, 16'h4321, 16'h0001, 1'b0, 1'b0, "in_reset");
        rst = 1'b0;
        chk_reset("reset");

        // single request: result at t+5, idle again at t+6
        tick(1'b1, 16'h0010, 16'h0004, 1'b0, '0, '0, 1'b1, 1'b0, "single");
        repeat (4) tick_idle();
        chk("single_busy", {31'd0, idle}, 32'd0);
        tick_idle();
        chk("single_idle", {31'd0, idle}, 32'd1);
        chk("single_done", {31'd0, res_valid}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].r0, vecs[i].a0, vecs[i].b0, vecs[i].r1, vecs[i].a1, vecs[i].b1,
                 vecs[i].g0, vecs[i].g1, $sformatf("vec%0d", i));
        end
        drain("table");

        // reset mid-flight: three issues leave ptr=1, then rst discards them
        tick(1'b1, 16'hA000, 16'h0A00, 1'b0, '0, '0, 1'b1, 1'b0, "mid_a");
        tick(1'b1, 16'hA100, 16'h0A10, 1'b0, '0, '0, 1'b1, 1'b0, "mid_b");
        tick(1'b1, 16'hA200, 16'h0A20, 1'b0, '0, '0, 1'b1, 1'b0, "mid_c");
        tick_idle();
        rst = 1'b1;
        sb.delete();
        tick(1'b1, 16'hB000, 16'h0B00, 1'b1, 16'hC000, 16'h0C00, 1'b0, 1'b0, "mid_rst");
        rst = 1'b0;
        chk_reset("mid_reset");
        repeat (6) tick_idle();

        // pointer was cleared: joint request goes to requester 0 first
        tick(1'b1, 16'hD000, 16'h0D00, 1'b1, 16'hE000, 16'h0E00, 1'b1, 1'b0, "post_rst_0");
        tick(1'b0, '0, '0, 1'b1, 16'hE000, 16'h0E00, 1'b0, 1'b1, "post_rst_1");
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
